// File: rtl/spi_slave_rx_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : spi_slave_rx_tx_if
// Description : Pin and word-level bundle of the SPI mode-0 slave.
// Revision    : 1.0 - initial release
//==============================================================================
interface spi_slave_rx_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  sclk_i;
   logic                  cs_n_i;
   logic                  mosi_i;
   logic                  miso_o;
   logic                  miso_oe_o;
   logic [DATA_WIDTH-1:0] tx_data_i;
   logic                  tx_load_i;
   logic                  tx_ready_o;
   logic [DATA_WIDTH-1:0] rx_data_o;
   logic                  rx_valid_o;
   logic                  busy_o;
   logic                  frame_err_o;

   modport slave (
      input  sclk_i, cs_n_i, mosi_i, tx_data_i, tx_load_i,
      output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, busy_o, frame_err_o
   );

   modport master (
      output sclk_i, cs_n_i, mosi_i, tx_data_i, tx_load_i,
      input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o, busy_o, frame_err_o
   );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx_tx.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : spi_slave_rx_tx
// Description : Oversampling SPI mode-0 slave, MSB first, back-to-back words.
// Revision    : 1.0 - initial release
//==============================================================================
module spi_slave_rx_tx #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk_10MHz,
   input  logic                   rst_i,
   spi_slave_rx_tx_if.slave       bus
);

   localparam int                 c_cnt_w    = $clog2(DATA_WIDTH);
   localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_ACTIVE    = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;

   logic [SYNC_STAGES-1:0]  r_sclk_sync;
   logic [SYNC_STAGES-1:0]  r_cs_sync;
   logic [SYNC_STAGES-1:0]  r_mosi_sync;
   logic                    r_sclk_prev;
   logic                    r_cs_prev;

   logic                    w_sclk;
   logic                    w_cs_n;
   logic                    w_mosi;
   logic                    w_sclk_rise;
   logic                    w_sclk_fall;
   logic                    w_cs_rise;
   logic                    w_cs_fall;

   logic                    w_load;
   logic                    w_start;
   logic                    w_rise;
   logic                    w_fall;
   logic                    w_stop;
   logic                    w_last;
   logic [DATA_WIDTH-1:0]   w_rx_next;

   logic [DATA_WIDTH-1:0]   r_holding;
   logic [DATA_WIDTH-1:0]   r_tx_shift;
   logic [DATA_WIDTH-2:0]   r_rx_shift;
   logic [DATA_WIDTH-1:0]   r_rx_data;
   logic [c_cnt_w-1:0]      r_bit_cnt;
   logic                    r_reload_pending;
   logic                    r_miso_oe;
   logic                    r_rx_valid;
   logic                    r_frame_err;

   // The CS_N chain resets low so WAIT_IDLE only leaves on a genuinely sampled high.
   always_ff @(posedge clk_10MHz or posedge rst_i) begin
      if (rst_i) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n_i};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk &  r_sclk_prev;
   assign w_cs_rise   =  w_cs_n & ~r_cs_prev;
   assign w_cs_fall   = ~w_cs_n &  r_cs_prev;

   always_ff @(posedge clk_10MHz or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_WAIT_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // CS edges outrank SCLK edges; SCLK is only looked at inside an active frame.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_start      = 1'b0;
      w_rise       = 1'b0;
      w_fall       = 1'b0;
      w_stop       = 1'b0;
      case (r_state)
         ST_WAIT_IDLE: begin
            if (w_cs_n) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            w_load = bus.tx_load_i;
            if (w_cs_fall) begin
               w_start      = 1'b1;
               w_state_next = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (w_cs_rise) begin
               w_stop       = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_sclk_rise) begin
               w_rise = 1'b1;
            end else if (w_sclk_fall) begin
               w_fall = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_WAIT_IDLE;
         end
      endcase
   end

   assign w_last    = (r_bit_cnt == c_last_bit);
   assign w_rx_next = {r_rx_shift, w_mosi};

   // MISO is the MSB of tx_shift. The reload for the next word is deferred from the
   // final rising edge to the following fall so the last bit stays on the wire.
   always_ff @(posedge clk_10MHz or posedge rst_i) begin
      if (rst_i) begin
         r_holding        <= '0;
         r_tx_shift       <= '0;
         r_rx_shift       <= '0;
         r_rx_data        <= '0;
         r_bit_cnt        <= '0;
         r_reload_pending <= 1'b0;
         r_miso_oe        <= 1'b0;
         r_rx_valid       <= 1'b0;
         r_frame_err      <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;

         if (w_load) begin
            r_holding <= bus.tx_data_i;
         end

         if (w_start) begin
            r_bit_cnt        <= '0;
            r_tx_shift       <= r_holding;
            r_rx_shift       <= '0;
            r_reload_pending <= 1'b0;
            r_miso_oe        <= 1'b1;
         end

         if (w_rise) begin
            r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
            if (w_last) begin
               r_bit_cnt        <= '0;
               r_rx_data        <= w_rx_next;
               r_rx_valid       <= 1'b1;
               r_reload_pending <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end

         if (w_fall) begin
            if (r_reload_pending) begin
               r_tx_shift       <= r_holding;
               r_reload_pending <= 1'b0;
            end else begin
               r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
         end

         if (w_stop) begin
            r_tx_shift       <= '0;
            r_bit_cnt        <= '0;
            r_reload_pending <= 1'b0;
            r_miso_oe        <= 1'b0;
            r_frame_err      <= (r_bit_cnt != '0);
         end
      end
   end

   assign bus.miso_o      = r_tx_shift[DATA_WIDTH-1];
   assign bus.miso_oe_o   = r_miso_oe;
   assign bus.tx_ready_o  = (r_state == ST_IDLE);
   assign bus.busy_o      = (r_state == ST_ACTIVE);
   assign bus.rx_data_o   = r_rx_data;
   assign bus.rx_valid_o  = r_rx_valid;
   assign bus.frame_err_o = r_frame_err;

endmodule
`default_nettype wire
